// File: rtl/datainf_sink_pkg.sv
// Shared types and constants for the data_inf terminating sink.
package datainf_sink_pkg;

  typedef enum logic [1:0] {
    RDY_ALWAYS   = 2'd0,
    RDY_NEVER    = 2'd1,
    RDY_PERIODIC = 2'd2,
    RDY_RANDOM   = 2'd3
  } ready_mode_e;

  localparam int unsigned LFSR_W       = 16;
  // Taps 16,14,13,11 of a Fibonacci LFSR that shifts toward the MSB.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/datainf_ready_gen.sv
// Registered ready generator: always, never, periodic duty cycle or LFSR backpressure.
module datainf_ready_gen
  import datainf_sink_pkg::*;
#(
  parameter int unsigned       MODE      = 0,
  parameter int unsigned       PERIOD    = 4,
  parameter int unsigned       ON_CYCLES = 2,
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
  input  logic clock,
  input  logic rst_n,
  input  logic enable,
  output logic ready
);

  localparam int unsigned PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam ready_mode_e MODE_E = ready_mode_e'(MODE[1:0]);

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              ready_q, ready_d;
  logic              fb;

  // Advance the pattern state while enabled and pick next-cycle ready from the mode.
  // Ready is derived from the post-step generator state so it never looks at valid.
  always_comb begin
    pcnt_d  = pcnt_q;
    lfsr_d  = lfsr_q;
    ready_d = 1'b0;
    fb      = ^(lfsr_q & LFSR_TAPS);
    if (enable) begin
      pcnt_d = (pcnt_q == PCNT_W'(PERIOD - 1)) ? '0 : pcnt_q + PCNT_W'(1);
      lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
    end
    case (MODE_E)
      RDY_ALWAYS:   ready_d = enable;
      RDY_NEVER:    ready_d = 1'b0;
      RDY_PERIODIC: ready_d = enable && (32'(pcnt_d) < ON_CYCLES);
      RDY_RANDOM:   ready_d = enable && lfsr_d[0];
      default:      ready_d = 1'b0;
    endcase
  end

  // Generator state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      pcnt_q  <= '0;
      lfsr_q  <= SEED;
      ready_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      lfsr_q  <= lfsr_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/datainf_slaver_sink.sv
// Terminating data_inf sink with selectable backpressure and beat/stall statistics.
module datainf_slaver_sink
  import datainf_sink_pkg::*;
#(
  parameter int unsigned       DSIZE     = 8,
  parameter int unsigned       MODE      = 0,
  parameter int unsigned       PERIOD    = 4,
  parameter int unsigned       ON_CYCLES = 2,
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             slaver_valid,
  input  logic [DSIZE-1:0] slaver_data,
  output logic             slaver_ready,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [DSIZE-1:0] last_data,
  output logic [DSIZE-1:0] xor_sum
);

  // Reject illegal parameter combinations at elaboration.
  if (PERIOD < 1)         begin : g_bad_period $error("PERIOD must be >= 1"); end
  if (ON_CYCLES > PERIOD) begin : g_bad_on     $error("ON_CYCLES must be <= PERIOD"); end
  if (SEED == '0)         begin : g_bad_seed   $error("SEED must be nonzero"); end
  if (MODE > 3)           begin : g_bad_mode   $error("MODE must be 0..3"); end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             ready;
  logic             accept_c;
  logic             stall_c;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [DSIZE-1:0] last_q, last_d;
  logic [DSIZE-1:0] xor_q, xor_d;

  datainf_ready_gen #(
    .MODE      (MODE),
    .PERIOD    (PERIOD),
    .ON_CYCLES (ON_CYCLES),
    .SEED      (SEED)
  ) u_ready_gen (
    .clock  (clock),
    .rst_n  (rst_n),
    .enable (enable),
    .ready  (ready)
  );

  assign accept_c = slaver_valid && ready;
  assign stall_c  = slaver_valid && !ready;

  // Statistics update; clear wins over a same-cycle accept or stall.
  always_comb begin
    beat_d  = beat_q;
    stall_d = stall_q;
    last_d  = last_q;
    xor_d   = xor_q;
    if (clear) begin
      beat_d  = '0;
      stall_d = '0;
      last_d  = '0;
      xor_d   = '0;
    end else if (accept_c) begin
      beat_d = (beat_q == CNT_MAX) ? beat_q : beat_q + CNT_W'(1);
      last_d = slaver_data;
      xor_d  = xor_q ^ slaver_data;
    end else if (stall_c) begin
      stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_W'(1);
    end
  end

  // Statistics registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      beat_q  <= '0;
      stall_q <= '0;
      last_q  <= '0;
      xor_q   <= '0;
    end else begin
      beat_q  <= beat_d;
      stall_q <= stall_d;
      last_q  <= last_d;
      xor_q   <= xor_d;
    end
  end

  assign slaver_ready = ready;
  assign beat_cnt     = beat_q;
  assign stall_cnt    = stall_q;
  assign last_data    = last_q;
  assign xor_sum      = xor_q;

endmodule

// File: tb/tb_datainf_slaver_sink.sv
// Scoreboard bench: four sinks (ALWAYS w/ 4-bit counters, PERIODIC 4/1, NEVER, RANDOM)
// share one stimulus stream and are checked against a cycle reference model.
module tb_datainf_slaver_sink;

  localparam int          MODES [4] = '{0, 2, 1, 3};
  localparam int          PER   [4] = '{4, 4, 4, 4};
  localparam int          ONC   [4] = '{2, 1, 2, 2};
  localparam int unsigned CAP   [4] = '{32'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [15:0] SEED_V    = 16'hACE1;

  logic       clock = 1'b0;
  logic       rst_n, valid, enable, clear;
  logic [7:0] data;

  logic        rdy   [4];
  logic [31:0] dbeat [4];
  logic [31:0] dstall[4];
  logic [7:0]  dlast [4];
  logic [7:0]  dxor  [4];
  logic [3:0]  a_beat, a_stall;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  // Reference model state
  bit          m_ready[4];
  int unsigned m_beat [4];
  int unsigned m_stall[4];
  logic [7:0]  m_last [4];
  logic [7:0]  m_xor  [4];
  int          m_pcnt [4];
  logic [15:0] m_lfsr [4];
  logic [7:0]  exp_q  [4][$];

  always #5 clock = ~clock;

  assign dbeat[0]  = 32'(a_beat);
  assign dstall[0] = 32'(a_stall);

  datainf_slaver_sink #(.MODE(0), .CNT_W(4)) u_always (
    .clock(clock), .rst_n(rst_n), .slaver_valid(valid), .slaver_data(data),
    .slaver_ready(rdy[0]), .enable(enable), .clear(clear),
    .beat_cnt(a_beat), .stall_cnt(a_stall), .last_data(dlast[0]), .xor_sum(dxor[0]));

  datainf_slaver_sink #(.MODE(2), .PERIOD(4), .ON_CYCLES(1)) u_periodic (
    .clock(clock), .rst_n(rst_n), .slaver_valid(valid), .slaver_data(data),
    .slaver_ready(rdy[1]), .enable(enable), .clear(clear),
    .beat_cnt(dbeat[1]), .stall_cnt(dstall[1]), .last_data(dlast[1]), .xor_sum(dxor[1]));

  datainf_slaver_sink #(.MODE(1)) u_never (
    .clock(clock), .rst_n(rst_n), .slaver_valid(valid), .slaver_data(data),
    .slaver_ready(rdy[2]), .enable(enable), .clear(clear),
    .beat_cnt(dbeat[2]), .stall_cnt(dstall[2]), .last_data(dlast[2]), .xor_sum(dxor[2]));

  datainf_slaver_sink #(.MODE(3), .SEED(16'hACE1)) u_random (
    .clock(clock), .rst_n(rst_n), .slaver_valid(valid), .slaver_data(data),
    .slaver_ready(rdy[3]), .enable(enable), .clear(clear),
    .beat_cnt(dbeat[3]), .stall_cnt(dstall[3]), .last_data(dlast[3]), .xor_sum(dxor[3]));

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11, new bit enters at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Apply the clock-edge rules to the model using the inputs held over that edge.
  function automatic void model_step();
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_ready[i] = 1'b0; m_beat[i] = 0; m_stall[i] = 0;
        m_last[i] = '0; m_xor[i] = '0; m_pcnt[i] = 0; m_lfsr[i] = SEED_V;
      end else begin
        if (clear) begin
          m_beat[i] = 0; m_stall[i] = 0; m_last[i] = '0; m_xor[i] = '0;
        end else if (valid && m_ready[i]) begin
          if (m_beat[i] < CAP[i]) m_beat[i]++;
          m_last[i] = data;
          m_xor[i]  = m_xor[i] ^ data;
        end else if (valid) begin
          if (m_stall[i] < CAP[i]) m_stall[i]++;
        end
        if (enable) begin
          m_pcnt[i] = (m_pcnt[i] + 1) % PER[i];
          m_lfsr[i] = lfsr_next(m_lfsr[i]);
        end
        case (MODES[i])
          0:       m_ready[i] = enable;
          1:       m_ready[i] = 1'b0;
          2:       m_ready[i] = enable && (m_pcnt[i] < ONC[i]);
          default: m_ready[i] = enable && m_lfsr[i][0];
        endcase
      end
    end
  endfunction

  // One clock of stimulus; expected accepted beats go to the scoreboard first.
  task automatic cyc(input bit r, input bit v, input bit en, input bit clr, input logic [7:0] d);
    rst_n = r; valid = v; enable = en; clear = clr; data = d;
    for (int i = 0; i < 4; i++)
      if (r && v && m_ready[i]) exp_q[i].push_back(d);
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic check_stats(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s beat_cnt[%0d]", tag, i),  dbeat[i],  longint'(m_beat[i]));
      chk($sformatf("%s stall_cnt[%0d]", tag, i), dstall[i], longint'(m_stall[i]));
      chk($sformatf("%s last_data[%0d]", tag, i), dlast[i],  m_last[i]);
      chk($sformatf("%s xor_sum[%0d]", tag, i),   dxor[i],   m_xor[i]);
    end
  endtask

  // Monitor: compare ready each cycle and pop the scoreboard on every observed handshake.
  always @(negedge clock) begin
    if (started) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ready[%0d]", i), rdy[i], m_ready[i]);
        if (rst_n && valid && rdy[i]) begin
          chk($sformatf("beat expected[%0d]", i), exp_q[i].size() > 0, 1);
          if (exp_q[i].size() > 0)
            chk($sformatf("beat data[%0d]", i), data, exp_q[i].pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; enable = 1'b1; clear = 1'b0; data = '0;
    cyc(0, 0, 1, 0, 8'h00);
    started = 1'b1;
    cyc(0, 1, 1, 0, 8'hFF);
    check_stats("reset");

    for (int k = 1; k <= 10; k++) cyc(1, 1, 1, 0, 8'(k));
    check_stats("burst");
    chk("always beat_cnt after burst", dbeat[0], 9);
    chk("always xor after burst", dxor[0], 8'h0A ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^
        8'h05 ^ 8'h06 ^ 8'h07 ^ 8'h08 ^ 8'h09 ^ 8'h01);

    for (int k = 0; k < 40; k++) cyc(1, 1, 1, 0, 8'($urandom));
    check_stats("steady");
    for (int k = 0; k < 64; k++)
      cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 0, 8'($urandom));
    check_stats("random");

    for (int k = 0; k < 3; k++) cyc(1, 1, 1, 0, 8'(8'h21 + k));
    cyc(1, 1, 1, 1, 8'h5A);
    check_stats("clear");
    chk("always beat_cnt on clear", dbeat[0], 0);
    chk("always last_data on clear", dlast[0], 0);
    cyc(1, 1, 1, 0, 8'h11);
    check_stats("post clear");
    chk("always beat_cnt after clear", dbeat[0], 1);
    chk("always last_data after clear", dlast[0], 8'h11);

    for (int k = 0; k < 20; k++) cyc(1, 1, 1, 0, 8'($urandom));
    check_stats("saturate");
    chk("always beat_cnt saturated", dbeat[0], 15);

    cyc(0, 1, 1, 0, 8'h77);
    check_stats("mid reset");
    for (int i = 0; i < 4; i++) chk($sformatf("ready after reset[%0d]", i), rdy[i], 0);

    for (int k = 0; k < 30; k++) cyc(1, 1, $urandom_range(0, 5) != 0, 0, 8'($urandom));
    check_stats("after reset");

    cyc(1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++)
      chk($sformatf("scoreboard drained[%0d]", i), exp_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
